// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SERVE_I = 2'b01,
        ST_SERVE_D = 2'b10
    } arb_state_t;

    // Enable bit positions inside the D_READ / D_WRITE control fields
    localparam int unsigned READ_EN_BIT  = 3;
    localparam int unsigned WRITE_EN_BIT = 2;

    // Instruction fetches are issued to memory as a word load (enable + funct3 = 3'b010)
    localparam logic [3:0] IFETCH_READ = 4'b1010;

    // A data request is pending when either its read or its write enable is set
    function automatic logic data_pending(input logic [3:0] rd, input logic [2:0] wr);
        return rd[READ_EN_BIT] | wr[WRITE_EN_BIT];
    endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Counts busy cycles of the transaction in service; flags the last allowed cycle.
module arb_timeout_counter #(
    parameter int unsigned LIMIT = 256
) (
    input  logic CLK,
    input  logic RESET,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_limit
);

    localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] r_count;

    // Busy-cycle count, held at zero whenever no transaction is in service
    always_ff @(posedge CLK) begin
        if (RESET || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CW'(1);
        end
    end

    // High during the LIMIT-th busy cycle; the abort happens on the following edge
    assign o_limit = (r_count == LAST);

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates a single memory port between instruction fetch and data access.
module memory_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic        DATA_FIRST     = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        I_READ,
    input  logic [31:0] I_ADDR,
    output logic [31:0] I_READ_DATA,
    output logic        I_BUSYWAIT,
    input  logic [3:0]  D_READ,
    input  logic [2:0]  D_WRITE,
    input  logic [31:0] D_ADDR,
    input  logic [31:0] D_WRITE_DATA,
    output logic [31:0] D_READ_DATA,
    output logic        D_BUSYWAIT,
    output logic [3:0]  MEM_READ,
    output logic [2:0]  MEM_WRITE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WRITE_DATA,
    input  logic [31:0] MEM_READ_DATA,
    input  logic        MEM_BUSYWAIT,
    output logic        GRANT_I,
    output logic        GRANT_D,
    output logic        ERROR
);

    arb_state_t  r_state;
    arb_state_t  w_next_state;
    logic        w_pick_d;

    logic [3:0]  r_req_read;
    logic [2:0]  r_req_write;
    logic [31:0] r_req_addr;
    logic [31:0] r_req_wdata;

    logic        r_last_valid;
    logic        r_last_d;
    logic        r_error;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;

    logic        w_pend_i;
    logic        w_pend_d;
    logic        w_serve_i;
    logic        w_serve_d;
    logic        w_serving;
    logic        w_busy_cycle;
    logic        w_limit;
    logic        w_timeout;
    logic        w_match_i;
    logic        w_match_d;
    logic        w_done_i;
    logic        w_done_d;
    logic        w_abort_i;
    logic        w_abort_d;

    assign w_pend_i     = I_READ;
    assign w_pend_d     = data_pending(D_READ, D_WRITE);
    assign w_serve_i    = (r_state == ST_SERVE_I);
    assign w_serve_d    = (r_state == ST_SERVE_D);
    assign w_serving    = w_serve_i | w_serve_d;
    assign w_busy_cycle = w_serving & MEM_BUSYWAIT;
    assign w_timeout    = w_busy_cycle & w_limit;

    arb_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .CLK      (CLK),
        .RESET    (RESET),
        .i_clear  (~w_serving),
        .i_enable (w_busy_cycle),
        .o_limit  (w_limit)
    );

    // A requester only receives the result if its live request still matches the latched one
    assign w_match_i = (I_ADDR == r_req_addr);
    assign w_match_d = (D_READ == r_req_read) && (D_WRITE == r_req_write) &&
                       (D_ADDR == r_req_addr) && (D_WRITE_DATA == r_req_wdata);

    assign w_done_i  = w_serve_i & ~MEM_BUSYWAIT & w_pend_i & w_match_i;
    assign w_done_d  = w_serve_d & ~MEM_BUSYWAIT & w_pend_d & w_match_d;
    assign w_abort_i = w_serve_i & w_timeout;
    assign w_abort_d = w_serve_d & w_timeout;

    assign I_BUSYWAIT  = w_pend_i & ~(w_done_i | w_abort_i);
    assign D_BUSYWAIT  = w_pend_d & ~(w_done_d | w_abort_d);
    assign I_READ_DATA = w_done_i ? MEM_READ_DATA : (w_abort_i ? '0 : r_i_rdata);
    assign D_READ_DATA = w_done_d ? MEM_READ_DATA : (w_abort_d ? '0 : r_d_rdata);
    assign ERROR       = r_error;

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state arbitration and memory-side outputs
    always_comb begin
        w_next_state   = r_state;
        w_pick_d       = 1'b0;
        GRANT_I        = 1'b0;
        GRANT_D        = 1'b0;
        MEM_READ       = '0;
        MEM_WRITE      = '0;
        MEM_ADDR       = '0;
        MEM_WRITE_DATA = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pend_i && w_pend_d) begin
                    w_pick_d = r_last_valid ? ~r_last_d : DATA_FIRST;
                end else begin
                    w_pick_d = w_pend_d;
                end
                if (w_pend_i || w_pend_d) begin
                    w_next_state = w_pick_d ? ST_SERVE_D : ST_SERVE_I;
                end
            end
            ST_SERVE_I, ST_SERVE_D: begin
                GRANT_I        = w_serve_i;
                GRANT_D        = w_serve_d;
                MEM_READ       = r_req_read;
                MEM_WRITE      = r_req_write;
                MEM_ADDR       = r_req_addr;
                MEM_WRITE_DATA = r_req_wdata;
                if (!MEM_BUSYWAIT || w_timeout) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Capture the granted request and remember which port won
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_req_read   <= '0;
            r_req_write  <= '0;
            r_req_addr   <= '0;
            r_req_wdata  <= '0;
            r_last_valid <= 1'b0;
            r_last_d     <= 1'b0;
        end else if (r_state == ST_IDLE && w_next_state != ST_IDLE) begin
            r_last_valid <= 1'b1;
            r_last_d     <= (w_next_state == ST_SERVE_D);
            if (w_next_state == ST_SERVE_D) begin
                r_req_read  <= D_READ;
                r_req_write <= D_WRITE;
                r_req_addr  <= D_ADDR;
                r_req_wdata <= D_WRITE_DATA;
            end else begin
                r_req_read  <= IFETCH_READ;
                r_req_write <= '0;
                r_req_addr  <= I_ADDR;
                r_req_wdata <= '0;
            end
        end
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_error <= 1'b0;
        end else if (w_timeout) begin
            r_error <= 1'b1;
        end
    end

    // Hold the last result handed to each port; an abort hands out zero
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            if (w_done_i) begin
                r_i_rdata <= MEM_READ_DATA;
            end else if (w_abort_i) begin
                r_i_rdata <= '0;
            end
            if (w_done_d) begin
                r_d_rdata <= MEM_READ_DATA;
            end else if (w_abort_d) begin
                r_d_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus randomized traffic.
module tb_memory_arbiter;

    localparam logic TB_DATA_FIRST = 1'b1;

    logic        CLK;
    logic        RESET;
    logic        I_READ;
    logic [31:0] I_ADDR;
    logic [31:0] I_READ_DATA;
    logic        I_BUSYWAIT;
    logic [3:0]  D_READ;
    logic [2:0]  D_WRITE;
    logic [31:0] D_ADDR;
    logic [31:0] D_WRITE_DATA;
    logic [31:0] D_READ_DATA;
    logic        D_BUSYWAIT;
    logic [3:0]  MEM_READ;
    logic [2:0]  MEM_WRITE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WRITE_DATA;
    logic [31:0] MEM_READ_DATA;
    logic        MEM_BUSYWAIT;
    logic        GRANT_I;
    logic        GRANT_D;
    logic        ERROR;

    int total = 0;
    int bad   = 0;

    memory_arbiter #(
        .DATA_FIRST     (TB_DATA_FIRST),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .I_READ         (I_READ),
        .I_ADDR         (I_ADDR),
        .I_READ_DATA    (I_READ_DATA),
        .I_BUSYWAIT     (I_BUSYWAIT),
        .D_READ         (D_READ),
        .D_WRITE        (D_WRITE),
        .D_ADDR         (D_ADDR),
        .D_WRITE_DATA   (D_WRITE_DATA),
        .D_READ_DATA    (D_READ_DATA),
        .D_BUSYWAIT     (D_BUSYWAIT),
        .MEM_READ       (MEM_READ),
        .MEM_WRITE      (MEM_WRITE),
        .MEM_ADDR       (MEM_ADDR),
        .MEM_WRITE_DATA (MEM_WRITE_DATA),
        .MEM_READ_DATA  (MEM_READ_DATA),
        .MEM_BUSYWAIT   (MEM_BUSYWAIT),
        .GRANT_I        (GRANT_I),
        .GRANT_D        (GRANT_D),
        .ERROR          (ERROR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory contents are a fixed function of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5AA5A5;
    endfunction

    task automatic do_reset();
        RESET = 1'b1;
        I_READ = 1'b0; I_ADDR = '0;
        D_READ = '0; D_WRITE = '0; D_ADDR = '0; D_WRITE_DATA = '0;
        MEM_BUSYWAIT = 1'b0; MEM_READ_DATA = '0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
    endtask

    task automatic test_reset();
        MEM_READ_DATA = 32'hA5A5A5A5;
        #1;
        total++;
        if ({GRANT_I, GRANT_D, ERROR, I_BUSYWAIT, D_BUSYWAIT} !== 5'b0 ||
            MEM_READ !== 4'b0 || MEM_WRITE !== 3'b0 || MEM_ADDR !== 32'b0 || MEM_WRITE_DATA !== 32'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got gi=%b gd=%b err=%b ibw=%b dbw=%b mr=%h mw=%h ma=%h mwd=%h required all zero",
                     GRANT_I, GRANT_D, ERROR, I_BUSYWAIT, D_BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITE_DATA);
        end
        total++;
        if (I_READ_DATA !== 32'h0 || D_READ_DATA !== 32'h0) begin
            bad++;
            $display("FAIL reset_rdata: got i=%h d=%h required 0", I_READ_DATA, D_READ_DATA);
        end
    endtask

    task automatic test_single_fetch();
        @(posedge CLK); #1;
        I_READ = 1'b1; I_ADDR = 32'h40; MEM_BUSYWAIT = 1'b1; MEM_READ_DATA = '0;
        #1;
        total++;
        if (GRANT_I !== 1'b0 || I_BUSYWAIT !== 1'b1) begin
            bad++;
            $display("FAIL fetch_issue: got gi=%b ibw=%b required 0 1", GRANT_I, I_BUSYWAIT);
        end
        @(posedge CLK); #2;
        total++;
        if (GRANT_I !== 1'b1 || MEM_ADDR !== 32'h40 || MEM_READ[3] !== 1'b1 || MEM_WRITE !== 3'b0) begin
            bad++;
            $display("FAIL fetch_grant: got gi=%b addr=%h mr=%h mw=%h required 1 00000040 1xxx 0",
                     GRANT_I, MEM_ADDR, MEM_READ, MEM_WRITE);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK); #2;
            total++;
            if (I_BUSYWAIT !== 1'b1 || GRANT_I !== 1'b1) begin
                bad++;
                $display("FAIL fetch_busy[%0d]: got ibw=%b gi=%b required 1 1", i, I_BUSYWAIT, GRANT_I);
            end
        end
        @(posedge CLK); #1;
        MEM_BUSYWAIT = 1'b0; MEM_READ_DATA = 32'h00500093;
        #1;
        total++;
        if (I_BUSYWAIT !== 1'b0 || I_READ_DATA !== 32'h00500093) begin
            bad++;
            $display("FAIL fetch_done: got ibw=%b data=%h required 0 00500093", I_BUSYWAIT, I_READ_DATA);
        end
        @(posedge CLK); #1;
        I_READ = 1'b0; MEM_BUSYWAIT = 1'b1; MEM_READ_DATA = 32'hFFFFFFFF;
        #1;
        total++;
        if (GRANT_I !== 1'b0 || MEM_READ !== 4'b0 || I_READ_DATA !== 32'h00500093) begin
            bad++;
            $display("FAIL fetch_release: got gi=%b mr=%h data=%h required 0 0 00500093", GRANT_I, MEM_READ, I_READ_DATA);
        end
    endtask

    task automatic test_conflict_alternation();
        logic [1:0] exp_seq [8];
        exp_seq = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        do_reset();
        I_READ = 1'b1; I_ADDR = 32'h100;
        D_READ = 4'b1010; D_WRITE = 3'b000; D_ADDR = 32'h1000;
        MEM_BUSYWAIT = 1'b0; MEM_READ_DATA = 32'h12345678;
        for (int k = 0; k < 8; k++) begin
            @(posedge CLK); #2;
            total++;
            if ({GRANT_D, GRANT_I} !== exp_seq[k]) begin
                bad++;
                $display("FAIL conflict_grant[%0d]: got {d,i}=%b required %b", k, {GRANT_D, GRANT_I}, exp_seq[k]);
            end
            if (exp_seq[k] == 2'b10) begin
                total++;
                if (D_BUSYWAIT !== 1'b0 || I_BUSYWAIT !== 1'b1 || D_READ_DATA !== 32'h12345678) begin
                    bad++;
                    $display("FAIL conflict_dserve[%0d]: got dbw=%b ibw=%b ddata=%h required 0 1 12345678",
                             k, D_BUSYWAIT, I_BUSYWAIT, D_READ_DATA);
                end
            end
        end
        I_READ = 1'b0; D_READ = '0;
    endtask

    task automatic test_store();
        @(posedge CLK); #1;
        D_READ = '0; D_WRITE = 3'b110; D_ADDR = 32'h2004; D_WRITE_DATA = 32'hDEADBEEF; MEM_BUSYWAIT = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge CLK); #2;
            total++;
            if (MEM_WRITE !== 3'b110 || MEM_ADDR !== 32'h2004 || MEM_WRITE_DATA !== 32'hDEADBEEF ||
                MEM_READ !== 4'b0 || D_BUSYWAIT !== 1'b1 || GRANT_D !== 1'b1) begin
                bad++;
                $display("FAIL store_hold[%0d]: got mw=%b ma=%h mwd=%h mr=%h dbw=%b gd=%b required 110 00002004 deadbeef 0 1 1",
                         k, MEM_WRITE, MEM_ADDR, MEM_WRITE_DATA, MEM_READ, D_BUSYWAIT, GRANT_D);
            end
        end
        @(posedge CLK); #1;
        MEM_BUSYWAIT = 1'b0;
        #1;
        total++;
        if (D_BUSYWAIT !== 1'b0 || MEM_WRITE !== 3'b110) begin
            bad++;
            $display("FAIL store_done: got dbw=%b mw=%b required 0 110", D_BUSYWAIT, MEM_WRITE);
        end
        @(posedge CLK); #1;
        D_WRITE = '0; MEM_BUSYWAIT = 1'b1;
        #1;
        total++;
        if (MEM_WRITE !== 3'b0 || MEM_ADDR !== 32'h0 || MEM_WRITE_DATA !== 32'h0 || GRANT_D !== 1'b0) begin
            bad++;
            $display("FAIL store_idle: got mw=%b ma=%h mwd=%h gd=%b required zeros", MEM_WRITE, MEM_ADDR, MEM_WRITE_DATA, GRANT_D);
        end
    endtask

    task automatic test_branch_flush();
        do_reset();
        I_READ = 1'b1; I_ADDR = 32'h40; MEM_BUSYWAIT = 1'b1;
        @(posedge CLK); #2;
        total++;
        if (GRANT_I !== 1'b1 || MEM_ADDR !== 32'h40) begin
            bad++;
            $display("FAIL flush_first: got gi=%b addr=%h required 1 00000040", GRANT_I, MEM_ADDR);
        end
        @(posedge CLK); #1;
        I_ADDR = 32'h80;
        #1;
        total++;
        if (I_BUSYWAIT !== 1'b1 || MEM_ADDR !== 32'h40) begin
            bad++;
            $display("FAIL flush_latched: got ibw=%b addr=%h required 1 00000040", I_BUSYWAIT, MEM_ADDR);
        end
        @(posedge CLK); #1;
        MEM_BUSYWAIT = 1'b0; MEM_READ_DATA = 32'h11111111;
        #1;
        total++;
        if (I_BUSYWAIT !== 1'b1 || I_READ_DATA !== 32'h0) begin
            bad++;
            $display("FAIL flush_discard: got ibw=%b data=%h required 1 00000000", I_BUSYWAIT, I_READ_DATA);
        end
        @(posedge CLK); #1;
        MEM_BUSYWAIT = 1'b1;
        #1;
        total++;
        if (GRANT_I !== 1'b0 || I_BUSYWAIT !== 1'b1) begin
            bad++;
            $display("FAIL flush_idle: got gi=%b ibw=%b required 0 1", GRANT_I, I_BUSYWAIT);
        end
        @(posedge CLK); #2;
        total++;
        if (GRANT_I !== 1'b1 || MEM_ADDR !== 32'h80) begin
            bad++;
            $display("FAIL flush_second: got gi=%b addr=%h required 1 00000080", GRANT_I, MEM_ADDR);
        end
        @(posedge CLK); #1;
        MEM_BUSYWAIT = 1'b0; MEM_READ_DATA = 32'h22222222;
        #1;
        total++;
        if (I_BUSYWAIT !== 1'b0 || I_READ_DATA !== 32'h22222222) begin
            bad++;
            $display("FAIL flush_done: got ibw=%b data=%h required 0 22222222", I_BUSYWAIT, I_READ_DATA);
        end
        @(posedge CLK); #1;
        I_READ = 1'b0; MEM_BUSYWAIT = 1'b1; MEM_READ_DATA = 32'h33333333;
        #1;
        total++;
        if (I_READ_DATA !== 32'h22222222) begin
            bad++;
            $display("FAIL flush_hold: got data=%h required 22222222", I_READ_DATA);
        end
    endtask

    // Random requesters and a random-latency memory, checked against a transaction-level model
    task automatic test_random_traffic(input int unsigned ncyc);
        int          m_srv;   // 0 = none, 1 = instruction, 2 = data
        int          m_last;  // last granted port, 0 = none since reset
        bit          m_act;
        int unsigned m_lat;
        bit          drop_i;
        bit          drop_d;
        bit          pi;
        bit          pd;
        bit          done_i;
        bit          done_d;
        m_srv = 0; m_last = 0; m_act = 1'b0; m_lat = 0; drop_i = 1'b0; drop_d = 1'b0;
        do_reset();
        for (int unsigned c = 0; c < ncyc; c++) begin
            if (MEM_READ[3] || MEM_WRITE[2]) begin
                if (!m_act) begin
                    m_act = 1'b1;
                    m_lat = $urandom_range(0, 3);
                    total++;
                    if (m_srv == 1) begin
                        if (MEM_ADDR !== I_ADDR || MEM_WRITE !== 3'b0 || MEM_READ[3] !== 1'b1) begin
                            bad++;
                            $display("FAIL rnd_ireq c=%0d: got addr=%h mr=%h mw=%h required addr=%h fetch",
                                     c, MEM_ADDR, MEM_READ, MEM_WRITE, I_ADDR);
                        end
                    end else if (m_srv == 2) begin
                        if ({MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITE_DATA} !== {D_READ, D_WRITE, D_ADDR, D_WRITE_DATA}) begin
                            bad++;
                            $display("FAIL rnd_dreq c=%0d: got %h/%h/%h/%h required %h/%h/%h/%h", c,
                                     MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITE_DATA, D_READ, D_WRITE, D_ADDR, D_WRITE_DATA);
                        end
                    end else begin
                        bad++;
                        $display("FAIL rnd_spurious c=%0d: got memory request %h required none", c, MEM_ADDR);
                    end
                end
                MEM_BUSYWAIT  = (m_lat != 0);
                MEM_READ_DATA = (m_lat == 0) ? mem_word(MEM_ADDR) : $urandom;
                if (m_lat != 0) m_lat--;
            end else begin
                m_act = 1'b0;
                MEM_BUSYWAIT  = 1'($urandom_range(0, 1));
                MEM_READ_DATA = $urandom;
            end

            if (drop_i) begin I_READ = 1'b0; drop_i = 1'b0; end
            if (!I_READ && $urandom_range(0, 2) == 0) begin
                I_READ = 1'b1;
                I_ADDR = $urandom & 32'h0000_0FFC;
            end
            if (drop_d) begin D_READ = '0; D_WRITE = '0; drop_d = 1'b0; end
            if (!(D_READ[3] || D_WRITE[2]) && $urandom_range(0, 2) == 0) begin
                D_ADDR       = $urandom & 32'h0000_3FFC;
                D_WRITE_DATA = $urandom;
                if ($urandom_range(0, 1) == 1) begin
                    D_READ = 4'b1010; D_WRITE = 3'b000;
                end else begin
                    D_READ = 4'b0000; D_WRITE = 3'b110;
                end
            end
            #1;

            pi = I_READ;
            pd = D_READ[3] || D_WRITE[2];
            done_i = (m_srv == 1) && !MEM_BUSYWAIT;
            done_d = (m_srv == 2) && !MEM_BUSYWAIT;
            total++;
            if (GRANT_I !== (m_srv == 1) || GRANT_D !== (m_srv == 2)) begin
                bad++;
                $display("FAIL rnd_grant c=%0d: got gi=%b gd=%b required port %0d", c, GRANT_I, GRANT_D, m_srv);
            end
            total++;
            if (I_BUSYWAIT !== (pi && !done_i) || D_BUSYWAIT !== (pd && !done_d)) begin
                bad++;
                $display("FAIL rnd_busywait c=%0d: got ibw=%b dbw=%b required %b %b",
                         c, I_BUSYWAIT, D_BUSYWAIT, pi && !done_i, pd && !done_d);
            end
            if (done_i) begin
                total++;
                if (I_READ_DATA !== mem_word(I_ADDR)) begin
                    bad++;
                    $display("FAIL rnd_idata c=%0d: got %h required %h", c, I_READ_DATA, mem_word(I_ADDR));
                end
                drop_i = 1'b1;
            end
            if (done_d) begin
                if (D_READ[3]) begin
                    total++;
                    if (D_READ_DATA !== mem_word(D_ADDR)) begin
                        bad++;
                        $display("FAIL rnd_ddata c=%0d: got %h required %h", c, D_READ_DATA, mem_word(D_ADDR));
                    end
                end
                drop_d = 1'b1;
            end

            if (m_srv != 0) begin
                if (!MEM_BUSYWAIT) m_srv = 0;
            end else begin
                if (pi && pd) begin
                    if (m_last == 0) m_srv = TB_DATA_FIRST ? 2 : 1;
                    else             m_srv = (m_last == 2) ? 1 : 2;
                end else if (pd) begin
                    m_srv = 2;
                end else if (pi) begin
                    m_srv = 1;
                end
                if (m_srv != 0) m_last = m_srv;
            end
            @(posedge CLK); #1;
        end
        I_READ = 1'b0; D_READ = '0; D_WRITE = '0;
    endtask

    task automatic test_timeout();
        do_reset();
        D_READ = 4'b1010; D_ADDR = 32'h3000; MEM_BUSYWAIT = 1'b0; MEM_READ_DATA = 32'hCAFEF00D;
        @(posedge CLK); #2;
        total++;
        if (GRANT_D !== 1'b1 || D_BUSYWAIT !== 1'b0 || D_READ_DATA !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL tmo_preload: got gd=%b dbw=%b data=%h required 1 0 cafef00d", GRANT_D, D_BUSYWAIT, D_READ_DATA);
        end
        @(posedge CLK); #1;
        D_ADDR = 32'h3004; MEM_BUSYWAIT = 1'b1; MEM_READ_DATA = 32'hBAD0BAD0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge CLK); #2;
            total++;
            if (GRANT_D !== 1'b1 || D_BUSYWAIT !== 1'b1 || ERROR !== 1'b0 || D_READ_DATA !== 32'hCAFEF00D) begin
                bad++;
                $display("FAIL tmo_wait[%0d]: got gd=%b dbw=%b err=%b data=%h required 1 1 0 cafef00d",
                         k, GRANT_D, D_BUSYWAIT, ERROR, D_READ_DATA);
            end
        end
        @(posedge CLK); #2;
        total++;
        if (D_BUSYWAIT !== 1'b0 || D_READ_DATA !== 32'h0) begin
            bad++;
            $display("FAIL tmo_abort: got dbw=%b data=%h required 0 00000000", D_BUSYWAIT, D_READ_DATA);
        end
        @(posedge CLK); #1;
        D_READ = '0;
        #1;
        total++;
        if (GRANT_D !== 1'b0 || ERROR !== 1'b1 || MEM_READ !== 4'b0) begin
            bad++;
            $display("FAIL tmo_idle: got gd=%b err=%b mr=%h required 0 1 0", GRANT_D, ERROR, MEM_READ);
        end
        repeat (5) @(posedge CLK);
        #2;
        total++;
        if (ERROR !== 1'b1) begin
            bad++;
            $display("FAIL tmo_sticky: got err=%b required 1", ERROR);
        end
    endtask

    task automatic test_reset_mid_serve();
        @(posedge CLK); #1;
        D_READ = '0; D_WRITE = 3'b101; D_ADDR = 32'h2008; D_WRITE_DATA = 32'h0BADF00D; MEM_BUSYWAIT = 1'b1;
        @(posedge CLK); #2;
        total++;
        if (GRANT_D !== 1'b1 || MEM_WRITE !== 3'b101 || ERROR !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre: got gd=%b mw=%b err=%b required 1 101 1", GRANT_D, MEM_WRITE, ERROR);
        end
        @(posedge CLK); #1;
        RESET = 1'b1; MEM_BUSYWAIT = 1'b0; MEM_READ_DATA = 32'h77777777;
        @(posedge CLK); #2;
        total++;
        if (MEM_READ !== 4'b0 || MEM_WRITE !== 3'b0 || MEM_ADDR !== 32'h0 || MEM_WRITE_DATA !== 32'h0 ||
            GRANT_D !== 1'b0 || ERROR !== 1'b0 || D_READ_DATA !== 32'h0 || D_BUSYWAIT !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid: got mr=%h mw=%b ma=%h mwd=%h gd=%b err=%b ddata=%h dbw=%b required 0 0 0 0 0 0 0 1",
                     MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITE_DATA, GRANT_D, ERROR, D_READ_DATA, D_BUSYWAIT);
        end
        D_WRITE = '0;
        @(posedge CLK); #1;
        RESET = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        test_reset();
        test_single_fetch();
        test_conflict_alternation();
        test_store();
        test_branch_flush();
        test_random_traffic(400);
        test_timeout();
        test_reset_mid_serve();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter DATA_FIRST, default 1: tie-break priority after reset (1 = data port wins first conflict).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256: max cycles a granted transaction may stay busy before abort.
REQ-003 SHALL have port CLK  input  1  clock; all state updates on posedge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port I_READ  input  1  instruction fetch request.
REQ-006 SHALL have port I_ADDR  input  32  fetch address.
REQ-007 SHALL have port I_READ_DATA  output  32  fetched word.
REQ-008 SHALL have port I_BUSYWAIT  output  1  fetch stall.
REQ-009 SHALL have port D_READ  input  4  bit3 = read enable, [2:0] = funct3.
REQ-010 SHALL have port D_WRITE  input  3  bit2 = write enable, [1:0] = size.
REQ-011 SHALL have port D_ADDR  input  32  data address.
REQ-012 SHALL have port D_WRITE_DATA  input  32  store data.
REQ-013 SHALL have port D_READ_DATA  output  32  load data.
REQ-014 SHALL have port D_BUSYWAIT  output  1  data stall.
REQ-015 SHALL have ports MEM_READ  output  4, MEM_WRITE  output  3, MEM_ADDR  output  32, MEM_WRITE_DATA  output  32: unified memory request.
REQ-016 SHALL have ports MEM_READ_DATA  input  32 and MEM_BUSYWAIT  input  1: memory response.
REQ-017 SHALL have ports GRANT_I  output  1, GRANT_D  output  1, ERROR  output  1: status.

Function
REQ-018 A port is pending when I_READ=1 (instruction) or D_READ[3]|D_WRITE[2]=1 (data).
REQ-019 FSM states: IDLE, SERVE_I, SERVE_D; state and a registered copy of the granted request (address, read/write control, write data) update on posedge only.
REQ-020 IDLE: no pending -> IDLE; one pending -> serve it; both pending -> serve the port not granted last; with no grant since reset, DATA_FIRST selects.
REQ-021 In SERVE_x, MEM_* SHALL be driven from the latched copy; in IDLE, MEM_READ=0, MEM_WRITE=0, MEM_ADDR=0, MEM_WRITE_DATA=0.
REQ-022 Completion is a posedge in SERVE_x with MEM_BUSYWAIT=0; the FSM then returns to IDLE (no back-to-back grant; minimum latency request-to-release = 2 cycles).
REQ-023 x_BUSYWAIT = pending_x AND NOT (state=SERVE_x AND MEM_BUSYWAIT=0 AND live request equals latched request); combinational.
REQ-024 I_READ_DATA/D_READ_DATA SHALL pass MEM_READ_DATA when that port is in completing cycle, else hold last completed value.
REQ-025 Requester withdraws or changes request during SERVE_x: transaction still completes on memory, result discarded, busywait stays asserted if still pending; port re-arbitrated from IDLE.
REQ-026 Timeout counter clears on entering SERVE_x, increments each busy cycle; reaching TIMEOUT_CYCLES forces IDLE, sets ERROR sticky, deasserts that port's busywait for one cycle with read data 0.
REQ-027 GRANT_I=1 exactly in SERVE_I, GRANT_D=1 exactly in SERVE_D; never both.

Reset
REQ-028 RESET=1 at posedge: state IDLE, latched request 0, last-grant history cleared, counter 0, ERROR 0, held read data 0; takes priority over every other event including a completing transaction.
REQ-029 Reset mid-transaction: MEM_READ/MEM_WRITE=0 from the cycle after the reset edge; in-flight result discarded.

Structure
REQ-030 FSM state encodings and request-enable bit positions (read bit3, write bit2) SHALL live in shared package mem_arb_pkg.
REQ-031 Timeout counter SHALL be sub-module arb_timeout_counter (clear, enable, limit-reached output).

Verification
REQ-032 Single fetch I_ADDR=0x40, memory busy 3 cycles, returns 0x00500093 -> GRANT_I next cycle, I_BUSYWAIT low on completion cycle, I_READ_DATA=0x00500093.
REQ-033 I and D (load 0x1000) pending same cycle after reset, DATA_FIRST=1 -> SERVE_D first, then SERVE_I; repeated conflicts alternate D,I,D,I.
REQ-034 Store D_WRITE=3'b110, D_ADDR=0x2004, data 0xDEADBEEF -> MEM_WRITE=3'b110, MEM_ADDR=0x2004, MEM_WRITE_DATA=0xDEADBEEF held stable until completion.
REQ-035 Fetch address changes 0x40->0x80 mid-serve (branch flush) -> 0x40 result discarded, I_BUSYWAIT stays 1, 0x80 served next.
REQ-036 TIMEOUT_CYCLES=8, MEM_BUSYWAIT stuck 1 -> abort after 8 busy cycles, ERROR=1 until RESET, state IDLE.
REQ-037 RESET asserted during SERVE_D -> next cycle all MEM_* controls 0, GRANT_D=0, ERROR=0.
